alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Handshake and datapath-control bundle between the sequencer and its datapath.
// The sequencer takes the slave view; the datapath (or a test driver) takes the master view.
interface alu_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] IR;

  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [4:0]  alu_op;
  logic        busy, done, illegal;

  modport master (
    output start, mem_ready, IR,
    input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
    input  Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin,
    input  Rin, Rout, alu_op, busy, done, illegal
  );

  modport slave (
    input  start, mem_ready, IR,
    output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
    output Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin,
    output Rin, Rout, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/execute control sequencer for a bus-based ALU datapath; all outputs are
// Moore decodes of the state and the IR fields captured on the T2 -> T3 edge.
module alu_sequencer (
  input  logic          Clock,
  input  logic          Clear,
  alu_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, TRAP
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] opc_q, opc_d;
  logic [3:0] ra_q, ra_d;
  logic [3:0] rb_q, rb_d;
  logic [3:0] rc_q, rc_d;
  logic       md;
  logic       unused_ir;

  assign unused_ir = ^bus.IR[14:0];

  function automatic logic legal_op(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b01111, 5'b10000: legal_op = 1'b1;
      default:            legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      opc_q   <= 5'b0;
      ra_q    <= 4'b0;
      rb_q    <= 4'b0;
      rc_q    <= 4'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

  assign md = (opc_q == 5'b01111) || (opc_q == 5'b10000);

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    case (state_q)
      IDLE: if (bus.start) state_d = T0;
      T0:   state_d = T1;
      T1:   if (bus.mem_ready) state_d = T2;
      // Decode happens on the edge into T3 so that T3 already acts on the
      // captured fields, and an illegal opcode never shows any T3 strobe.
      T2: begin
        if (legal_op(bus.IR[31:27])) begin
          state_d = T3;
          opc_d   = bus.IR[31:27];
          ra_d    = bus.IR[26:23];
          rb_d    = bus.IR[22:19];
          rc_d    = bus.IR[18:15];
        end else begin
          state_d = TRAP;
        end
      end
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = md ? T6 : IDLE;
      T6:      state_d = IDLE;
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.ZLowIn   = 1'b0;
    bus.ZHighIn  = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.Rin      = 16'h0000;
    bus.Rout     = 16'h0000;
    bus.alu_op   = 5'b00000;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    case (state_q)
      T0: begin
        bus.busy  = 1'b1;
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
      end
      T1: begin
        bus.busy  = 1'b1;
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
      end
      T2: begin
        bus.busy   = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        bus.busy = 1'b1;
        bus.Yin  = 1'b1;
        bus.Rout = onehot(md ? ra_q : rb_q);
      end
      T4: begin
        bus.busy    = 1'b1;
        bus.ZLowIn  = 1'b1;
        bus.ZHighIn = md;
        bus.alu_op  = opc_q;
        bus.Rout    = onehot(md ? rb_q : rc_q);
      end
      T5: begin
        bus.busy    = 1'b1;
        bus.Zlowout = 1'b1;
        bus.LOin    = md;
        bus.Rin     = md ? 16'h0000 : onehot(ra_q);
        bus.done    = ~md;
      end
      T6: begin
        bus.busy     = 1'b1;
        bus.ZHighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
      end
      TRAP:    bus.illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Random and directed bench for alu_sequencer: each instruction is expanded into the
// cycle-by-cycle output vectors the sequencing rules imply, then compared every cycle.
module tb_alu_sequencer;

  logic Clock = 1'b0;
  logic Clear;
  always #5 Clock = ~Clock;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  alu_op;
    logic busy, done, illegal;
  } vec_t;

  int   n_asserts = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  vec_t expq[$];

  always @(posedge Clock) cyc <= cyc + 1;

  function automatic vec_t observe();
    vec_t o;
    o.PCout = bus.PCout;   o.MARin = bus.MARin;     o.IncPC = bus.IncPC;
    o.PCin = bus.PCin;     o.Read = bus.Read;       o.MDRin = bus.MDRin;
    o.MDRout = bus.MDRout; o.IRin = bus.IRin;       o.Yin = bus.Yin;
    o.ZLowIn = bus.ZLowIn; o.ZHighIn = bus.ZHighIn; o.Zlowout = bus.Zlowout;
    o.ZHighout = bus.ZHighout; o.LOin = bus.LOin;   o.HIin = bus.HIin;
    o.Rin = bus.Rin;       o.Rout = bus.Rout;       o.alu_op = bus.alu_op;
    o.busy = bus.busy;     o.done = bus.done;       o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic bit legal_op(input logic [4:0] op);
    return (op >= 5'd3 && op <= 5'd11) || op == 5'd15 || op == 5'd16;
  endfunction

  task automatic check(input string tag, input vec_t o, input vec_t e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Expected output per cycle after the start edge: fetch, w wait cycles, IR load, execute.
  task automatic build(input logic [31:0] ir, input int w);
    vec_t       e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit         md;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    md = (op == 5'd15) || (op == 5'd16);
    e = '0; e.busy = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; expq.push_back(e);
    for (int i = 0; i <= w; i++) begin
      e = '0; e.busy = 1; e.Read = 1; e.MDRin = 1; expq.push_back(e);
    end
    e = '0; e.busy = 1; e.MDRout = 1; e.IRin = 1; expq.push_back(e);
    if (!legal_op(op)) begin
      for (int i = 0; i < 4; i++) begin
        e = '0; e.illegal = 1; expq.push_back(e);
      end
      return;
    end
    e = '0; e.busy = 1; e.Yin = 1; e.Rout = 16'h1 << (md ? ra : rb); expq.push_back(e);
    e = '0; e.busy = 1; e.ZLowIn = 1; e.ZHighIn = md; e.alu_op = op;
    e.Rout = 16'h1 << (md ? rb : rc); expq.push_back(e);
    e = '0; e.busy = 1; e.Zlowout = 1;
    if (md) e.LOin = 1;
    else begin e.Rin = 16'h1 << ra; e.done = 1; end
    expq.push_back(e);
    if (md) begin
      e = '0; e.busy = 1; e.ZHighout = 1; e.HIin = 1; e.done = 1; expq.push_back(e);
    end
  endtask

  task automatic do_clear();
    #2;
    Clear     = 1'b1;
    bus.start = 1'b0;
    #1 check("clear_async", observe(), '0);
    @(negedge Clock);
    check("clear_hold", observe(), '0);
    Clear = 1'b0;
  endtask

  // Entered and left at a falling edge where the sequencer should be in IDLE.
  task automatic run(input logic [31:0] ir, input int w, input int abort_at,
                     output int lat, output int done_at);
    vec_t e;
    int   rd, idx, s;
    bit   aborted, trap;
    rd = 0; idx = 0; aborted = 0; lat = -1; done_at = -1; s = cyc;
    trap = !legal_op(ir[31:27]);
    check("idle_before_start", observe(), '0);
    build(ir, w);
    bus.IR        = ir;
    bus.start     = 1'b1;
    bus.mem_ready = 1'($urandom_range(0, 1));
    while (expq.size() > 0 && !aborted) begin
      @(negedge Clock);
      e = expq.pop_front();
      check($sformatf("ir%h_step%0d", ir, idx), observe(), e);
      if (e.done) begin lat = cyc - s; done_at = cyc; end
      bus.start = e.illegal ? 1'b1 : 1'($urandom_range(0, 1));
      if (e.Read) begin
        rd++;
        bus.mem_ready = (rd == w + 1);
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      if (e.Yin || e.ZLowIn || e.Zlowout || e.ZHighout || e.illegal) bus.IR = $urandom;
      if (idx == abort_at) begin
        do_clear();
        aborted = 1;
        expq.delete();
      end
      idx++;
    end
    if (trap && !aborted) do_clear();
    bus.start = 1'b0;
    @(negedge Clock);
  endtask

  int         lat, d1, d2, w, ab, full, done_idx;
  logic [4:0] op;
  logic [31:0] ir;
  bit          md;

  initial begin
    bus.start = 1'b0; bus.mem_ready = 1'b0; bus.IR = 32'h0; Clear = 1'b1;
    #1 check("reset_outputs", observe(), '0);
    @(negedge Clock);
    bus.start = 1'b1;
    @(negedge Clock);
    check("reset_ignores_start", observe(), '0);
    Clear = 1'b0; bus.start = 1'b0;
    @(negedge Clock);

    run(32'h4A920000, 0, -1, lat, d1);  check_int("or_latency", lat, 6);
    run(32'h4A920000, 3, -1, lat, d1);  check_int("memwait_latency", lat, 9);
    run(32'h7A900000, 0, -1, lat, d1);  check_int("mul_latency", lat, 7);
    run(32'hF8000000, 0, -1, lat, d1);  check_int("illegal_no_done", lat, -1);
    run(32'h4A920000, 0, 4, lat, d1);   check_int("abort_t4_no_done", lat, -1);
    run(32'h4A920000, 1, -1, lat, d1);  check_int("after_abort_latency", lat, 7);
    run(32'h18000000, 0, -1, lat, d1);  check_int("r0_latency", lat, 6);
    run(32'h1FFF8000, 2, -1, lat, d1);  check_int("r15_latency", lat, 8);
    run(32'h80B00000, 0, -1, lat, d1);  check_int("div_latency", lat, 7);

    run(32'h4A920000, 0, -1, lat, d1);
    run(32'h20A18000, 0, -1, lat, d2);
    check_int("back_to_back_spacing", d2 - d1, 7);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0)
        op = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(17, 31));
      else begin
        case ($urandom_range(0, 10))
          9:       op = 5'd15;
          10:      op = 5'd16;
          default: op = 5'($urandom_range(3, 11));
        endcase
      end
      ir = {op, 27'($urandom)};
      w  = $urandom_range(0, 4);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 5) : -1;
      md = (op == 5'd15) || (op == 5'd16);
      full     = (md ? 7 : 6) + w;
      done_idx = full - 1;
      run(ir, w, ab, lat, d1);
      if (!legal_op(op) || (ab >= 0 && ab < done_idx))
        check_int($sformatf("rand%0d_no_done", k), lat, -1);
      else
        check_int($sformatf("rand%0d_latency", k), lat, full);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
